// File: rtl/wt_cache_pkg.sv
// Shared types and geometry for the write-through dcache miss arbiter.
package wt_cache_pkg;

    localparam int unsigned PLEN                = 56;
    localparam int unsigned DCACHE_OFFSET_WIDTH = 6;
    localparam int unsigned DCACHE_LINE_WIDTH   = PLEN - DCACHE_OFFSET_WIDTH;
    localparam int unsigned CACHE_ID_WIDTH      = 3;

    typedef struct packed {
        logic [7:0]  NrCachedRegionRules;
        logic [63:0] CachedRegionAddrBase;
        logic [63:0] CachedRegionLength;
    } ariane_cfg_t;

    localparam ariane_cfg_t ArianeDefaultConfig = '{
        NrCachedRegionRules:  8'd1,
        CachedRegionAddrBase: 64'h0000_0000_8000_0000,
        CachedRegionLength:   64'h0000_0000_4000_0000
    };

    typedef enum logic [0:0] {
        FREE = 1'b0,
        PEND = 1'b1
    } miss_arb_state_e;

    typedef struct packed {
        miss_arb_state_e                state;
        logic [DCACHE_LINE_WIDTH-1:0]   line;
        logic                           nc;
    } miss_arb_entry_t;

    function automatic logic [DCACHE_LINE_WIDTH-1:0] dcache_line_addr(input logic [PLEN-1:0] paddr);
        return paddr[PLEN-1:DCACHE_OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/wt_dcache_miss_rr_arb.sv
// Combinational round-robin selector; the pointer only moves on advance_i,
// and lock_i pins the current winner for the next cycle.
module wt_dcache_miss_rr_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts = 3
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumPorts-1:0]       req_i,
    input  logic                      lock_i,
    input  logic                      advance_i,
    output logic                      gnt_vld_o,
    output logic [CACHE_ID_WIDTH-1:0] gnt_idx_o
);

    localparam int unsigned PadW = 2 ** CACHE_ID_WIDTH;

    logic [CACHE_ID_WIDTH-1:0] ptr_q, ptr_d;
    logic [CACHE_ID_WIDTH-1:0] lock_idx_q;
    logic                      lock_q;
    logic [PadW-1:0]           req_pad_s;
    logic [CACHE_ID_WIDTH:0]   cand_s;
    logic                      hit_s;

    // winner search starting at the pointer, unless a stalled winner is locked
    always_comb begin
        req_pad_s               = '0;
        req_pad_s[NumPorts-1:0] = req_i;
        gnt_vld_o               = 1'b0;
        gnt_idx_o               = '0;
        cand_s                  = '0;
        hit_s                   = 1'b0;
        if (lock_q && req_pad_s[lock_idx_q]) begin
            gnt_vld_o = 1'b1;
            gnt_idx_o = lock_idx_q;
        end else begin
            for (int unsigned i = 0; i < NumPorts; i++) begin
                cand_s = {1'b0, ptr_q} + (CACHE_ID_WIDTH+1)'(i);
                cand_s = (cand_s >= (CACHE_ID_WIDTH+1)'(NumPorts))
                       ? cand_s - (CACHE_ID_WIDTH+1)'(NumPorts) : cand_s;
                hit_s     = !gnt_vld_o && req_pad_s[cand_s[CACHE_ID_WIDTH-1:0]];
                gnt_idx_o = hit_s ? cand_s[CACHE_ID_WIDTH-1:0] : gnt_idx_o;
                gnt_vld_o = gnt_vld_o | hit_s;
            end
        end
    end

    // pointer moves to winner+1 only when the winner is resolved
    always_comb begin
        if (advance_i) begin
            ptr_d = (gnt_idx_o == CACHE_ID_WIDTH'(NumPorts - 1))
                  ? '0 : gnt_idx_o + CACHE_ID_WIDTH'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // pointer and lock registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q      <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else begin
            ptr_q      <= ptr_d;
            lock_q     <= lock_i;
            lock_idx_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/wt_dcache_miss_arb.sv
// Miss-request front-end: one outstanding miss per port, round-robin onto one memory channel,
// cacheline collision replay and return routing. Optional counters: WT_DCACHE_MISS_ARB_PERF_EN.
module wt_dcache_miss_arb
    import wt_cache_pkg::*;
#(
    parameter int unsigned NumPorts  = 3,
    parameter ariane_cfg_t ArianeCfg = ArianeDefaultConfig
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NumPorts-1:0]       miss_req_i,
    output logic [NumPorts-1:0]       miss_ack_o,
    output logic [NumPorts-1:0]       miss_replay_o,
    input  logic [NumPorts-1:0]       miss_nc_i,
    input  logic [NumPorts*PLEN-1:0]  miss_paddr_i,
    input  logic [NumPorts*3-1:0]     miss_size_i,
    output logic [NumPorts-1:0]       miss_rtrn_vld_o,
    output logic                      mem_req_o,
    input  logic                      mem_gnt_i,
    output logic [PLEN-1:0]           mem_paddr_o,
    output logic [2:0]                mem_size_o,
    output logic                      mem_nc_o,
    output logic [CACHE_ID_WIDTH-1:0] mem_tid_o,
    input  logic                      mem_rtrn_vld_i,
    input  logic [CACHE_ID_WIDTH-1:0] mem_rtrn_tid_i,
    output logic                      busy_o
`ifdef WT_DCACHE_MISS_ARB_PERF_EN
    ,
    output logic [31:0]               perf_miss_cnt_o,
    output logic [31:0]               perf_replay_cnt_o
`endif
);

    miss_arb_entry_t [NumPorts-1:0] entry_q, entry_d;
    logic [NumPorts-1:0]            pend_s, cand_s, sel_s, ack_s, replay_s, rtrn_s;
    logic                           win_vld_s, win_nc_s, collide_s, req_s, lock_s, advance_s;
    logic [CACHE_ID_WIDTH-1:0]      win_idx_s;
    logic [PLEN-1:0]                win_paddr_s;
    logic [2:0]                     win_size_s;
    logic [DCACHE_LINE_WIDTH-1:0]   win_line_s;
    logic                           busy_d, busy_q;
    logic                           unused_cfg_s;

    assign unused_cfg_s = ^ArianeCfg;

    always_comb begin
        for (int unsigned i = 0; i < NumPorts; i++) begin
            pend_s[i] = (entry_q[i].state == PEND);
        end
    end

    assign cand_s = miss_req_i & ~pend_s;

    wt_dcache_miss_rr_arb #(
        .NumPorts (NumPorts)
    ) i_rr_arb (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .req_i     (cand_s),
        .lock_i    (lock_s),
        .advance_i (advance_s),
        .gnt_vld_o (win_vld_s),
        .gnt_idx_o (win_idx_s)
    );

    // winner field mux and line-collision check against in-flight cacheable lines
    always_comb begin
        win_paddr_s = '0;
        win_size_s  = '0;
        win_nc_s    = 1'b0;
        collide_s   = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            sel_s[i]    = win_vld_s && (win_idx_s == CACHE_ID_WIDTH'(i));
            win_paddr_s = win_paddr_s | ({PLEN{sel_s[i]}} & miss_paddr_i[i*PLEN +: PLEN]);
            win_size_s  = win_size_s  | ({3{sel_s[i]}} & miss_size_i[i*3 +: 3]);
            win_nc_s    = win_nc_s    | (sel_s[i] & miss_nc_i[i]);
        end
        win_line_s = dcache_line_addr(win_paddr_s);
        for (int unsigned i = 0; i < NumPorts; i++) begin
            collide_s = collide_s | (pend_s[i] & ~entry_q[i].nc & (entry_q[i].line == win_line_s));
        end
        collide_s = collide_s & win_vld_s & ~win_nc_s;
    end

    assign req_s     = win_vld_s & ~collide_s;
    assign lock_s    = req_s & ~mem_gnt_i;
    assign advance_s = (req_s & mem_gnt_i) | (win_vld_s & collide_s);

    // a grant and a return never hit the same port: grants go to FREE entries, returns to PEND ones
    always_comb begin
        entry_d = entry_q;
        busy_d  = 1'b0;
        for (int unsigned i = 0; i < NumPorts; i++) begin
            ack_s[i]    = sel_s[i] & req_s & mem_gnt_i;
            replay_s[i] = sel_s[i] & collide_s;
            rtrn_s[i]   = mem_rtrn_vld_i & (mem_rtrn_tid_i == CACHE_ID_WIDTH'(i)) & pend_s[i];
            if (rtrn_s[i]) begin
                entry_d[i].state = FREE;
            end else if (ack_s[i]) begin
                entry_d[i].state = PEND;
                entry_d[i].line  = win_line_s;
                entry_d[i].nc    = win_nc_s;
            end else begin
                entry_d[i] = entry_q[i];
            end
            busy_d = busy_d | (entry_d[i].state == PEND);
        end
    end

    // entry table and busy flag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            entry_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            entry_q <= entry_d;
            busy_q  <= busy_d;
        end
    end

    assign miss_ack_o      = ack_s;
    assign miss_replay_o   = replay_s;
    assign miss_rtrn_vld_o = rtrn_s;
    assign mem_req_o       = req_s;
    assign mem_paddr_o     = req_s ? win_paddr_s : '0;
    assign mem_size_o      = req_s ? win_size_s : 3'b000;
    assign mem_nc_o        = req_s & win_nc_s;
    assign mem_tid_o       = req_s ? win_idx_s : '0;
    assign busy_o          = busy_q;

`ifdef WT_DCACHE_MISS_ARB_PERF_EN
    logic [31:0] perf_miss_q, perf_replay_q;

    // saturating ack and replay counters
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_miss_q   <= 32'd0;
            perf_replay_q <= 32'd0;
        end else begin
            if (|ack_s && (perf_miss_q != 32'hFFFF_FFFF)) begin
                perf_miss_q <= perf_miss_q + 32'd1;
            end
            if (|replay_s && (perf_replay_q != 32'hFFFF_FFFF)) begin
                perf_replay_q <= perf_replay_q + 32'd1;
            end
        end
    end

    assign perf_miss_cnt_o   = perf_miss_q;
    assign perf_replay_cnt_o = perf_replay_q;
`else
    // counters absent in this build
`endif

endmodule

// File: tb/tb_wt_dcache_miss_arb.sv
// Directed and randomized bench for wt_dcache_miss_arb against a per-cycle reference model.
module tb_wt_dcache_miss_arb;
    import wt_cache_pkg::*;

    localparam int unsigned N = 3;

    logic                      clk_i = 1'b0;
    logic                      rst_ni;
    logic [N-1:0]              miss_req_i, miss_ack_o, miss_replay_o, miss_nc_i, miss_rtrn_vld_o;
    logic [N*PLEN-1:0]         miss_paddr_i;
    logic [N*3-1:0]            miss_size_i;
    logic                      mem_req_o, mem_gnt_i, mem_nc_o, mem_rtrn_vld_i, busy_o;
    logic [PLEN-1:0]           mem_paddr_o;
    logic [2:0]                mem_size_o;
    logic [CACHE_ID_WIDTH-1:0] mem_tid_o, mem_rtrn_tid_i;

    wt_dcache_miss_arb #(.NumPorts(N)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .miss_req_i      (miss_req_i),
        .miss_ack_o      (miss_ack_o),
        .miss_replay_o   (miss_replay_o),
        .miss_nc_i       (miss_nc_i),
        .miss_paddr_i    (miss_paddr_i),
        .miss_size_i     (miss_size_i),
        .miss_rtrn_vld_o (miss_rtrn_vld_o),
        .mem_req_o       (mem_req_o),
        .mem_gnt_i       (mem_gnt_i),
        .mem_paddr_o     (mem_paddr_o),
        .mem_size_o      (mem_size_o),
        .mem_nc_o        (mem_nc_o),
        .mem_tid_o       (mem_tid_o),
        .mem_rtrn_vld_i  (mem_rtrn_vld_i),
        .mem_rtrn_tid_i  (mem_rtrn_tid_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // requester-side state
    bit              tb_req[N];
    bit              tb_nc[N];
    logic [PLEN-1:0] tb_paddr[N];
    logic [2:0]      tb_size[N];

    // reference model: outstanding line per port, rotating priority, stalled winner
    bit              m_pend[N];
    bit              m_nc[N];
    logic [PLEN-1:0] m_line[N];
    int              m_ptr, m_lock_port;
    bit              m_locked;

    int                        e_win;
    bit                        e_req, e_busy;
    logic [N-1:0]              e_ack, e_replay, e_rtrn;
    logic [PLEN-1:0]           e_paddr;
    logic [2:0]                e_size;
    bit                        e_nc;
    logic [CACHE_ID_WIDTH-1:0] e_tid;

    logic [N-1:0]              o_ack, o_replay, o_rtrn;
    logic                      o_req, o_nc, o_busy;
    logic [PLEN-1:0]           o_paddr;
    logic [2:0]                o_size;
    logic [CACHE_ID_WIDTH-1:0] o_tid;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            miss_req_i[p]                 = tb_req[p];
            miss_nc_i[p]                  = tb_nc[p];
            miss_paddr_i[p*PLEN +: PLEN]  = tb_paddr[p];
            miss_size_i[p*3 +: 3]         = tb_size[p];
        end
    endtask

    task automatic set_req(input int p, input logic [PLEN-1:0] a, input bit nc, input logic [2:0] sz);
        tb_req[p]   = 1'b1;
        tb_paddr[p] = a;
        tb_nc[p]    = nc;
        tb_size[p]  = sz;
    endtask

    task automatic model_eval();
        bit collide;
        int t;
        e_win   = -1;
        collide = 1'b0;
        if (m_locked && tb_req[m_lock_port] && !m_pend[m_lock_port]) begin
            e_win = m_lock_port;
        end else begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = (m_ptr + k) % N;
                if (e_win < 0 && tb_req[p] && !m_pend[p]) e_win = p;
            end
        end
        if (e_win >= 0 && !tb_nc[e_win]) begin
            for (int j = 0; j < N; j++) begin
                if (m_pend[j] && !m_nc[j] && m_line[j] == (tb_paddr[e_win] >> DCACHE_OFFSET_WIDTH))
                    collide = 1'b1;
            end
        end
        e_req    = (e_win >= 0) && !collide;
        e_ack    = '0;
        e_replay = '0;
        e_rtrn   = '0;
        if (e_win >= 0 && collide) e_replay = N'(1) << e_win;
        if (e_req && mem_gnt_i) e_ack = N'(1) << e_win;
        t = int'(mem_rtrn_tid_i);
        if (mem_rtrn_vld_i && t < N) begin
            if (m_pend[t]) e_rtrn = N'(1) << t;
        end
        e_paddr = e_req ? tb_paddr[e_win] : '0;
        e_size  = e_req ? tb_size[e_win] : 3'b000;
        e_nc    = e_req ? tb_nc[e_win] : 1'b0;
        e_tid   = e_req ? CACHE_ID_WIDTH'(e_win) : '0;
        e_busy  = 1'b0;
        for (int j = 0; j < N; j++) e_busy = e_busy | m_pend[j];
    endtask

    task automatic model_update();
        if (e_rtrn != '0) m_pend[int'(mem_rtrn_tid_i)] = 1'b0;
        if (e_ack != '0) begin
            m_pend[e_win]  = 1'b1;
            m_line[e_win]  = tb_paddr[e_win] >> DCACHE_OFFSET_WIDTH;
            m_nc[e_win]    = tb_nc[e_win];
            tb_req[e_win]  = 1'b0;
        end
        if (e_ack != '0 || e_replay != '0) m_ptr = (e_win + 1) % N;
        m_locked    = e_req && !mem_gnt_i;
        m_lock_port = e_win;
    endtask

    task automatic model_reset();
        for (int p = 0; p < N; p++) begin
            m_pend[p] = 1'b0;
            tb_req[p] = 1'b0;
        end
        m_ptr    = 0;
        m_locked = 1'b0;
    endtask

    // one clock: drive at edge+1, check mid-cycle, advance the model after the edge
    task automatic cycle(input bit gnt, input bit rv, input int tid);
        mem_gnt_i      = gnt;
        mem_rtrn_vld_i = rv;
        mem_rtrn_tid_i = CACHE_ID_WIDTH'(tid);
        drive();
        #3;
        model_eval();
        o_ack = miss_ack_o; o_replay = miss_replay_o; o_rtrn = miss_rtrn_vld_o;
        o_req = mem_req_o; o_paddr = mem_paddr_o; o_size = mem_size_o;
        o_nc = mem_nc_o; o_tid = mem_tid_o; o_busy = busy_o;
        chk("ack",    64'(o_ack),    64'(e_ack));
        chk("replay", 64'(o_replay), 64'(e_replay));
        chk("rtrn",   64'(o_rtrn),   64'(e_rtrn));
        chk("req",    64'(o_req),    64'(e_req));
        chk("paddr",  64'(o_paddr),  64'(e_paddr));
        chk("size",   64'(o_size),   64'(e_size));
        chk("nc",     64'(o_nc),     64'(e_nc));
        chk("tid",    64'(o_tid),    64'(e_tid));
        chk("busy",   64'(o_busy),   64'(e_busy));
        @(posedge clk_i);
        model_update();
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_req"},  64'(mem_req_o), 64'd0);
        chk({tag, "_ack"},  64'(miss_ack_o), 64'd0);
        chk({tag, "_rply"}, 64'(miss_replay_o), 64'd0);
        chk({tag, "_rtrn"}, 64'(miss_rtrn_vld_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd0);
        chk({tag, "_addr"}, 64'(mem_paddr_o), 64'd0);
    endtask

    task automatic do_reset();
        model_reset();
        mem_gnt_i      = 1'b0;
        mem_rtrn_vld_i = 1'b0;
        drive();
        #1;
        rst_ni = 1'b0;
        #1;
        check_idle("rst");
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni         = 1'b0;
        mem_gnt_i      = 1'b0;
        mem_rtrn_vld_i = 1'b0;
        mem_rtrn_tid_i = '0;
        for (int p = 0; p < N; p++) begin
            tb_nc[p] = 1'b0; tb_paddr[p] = '0; tb_size[p] = 3'b000;
            m_nc[p]  = 1'b0; m_line[p] = '0;
        end
        model_reset();
        m_lock_port = 0;
        drive();
        #3;
        check_idle("por");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // single cacheable miss, immediate grant, return two cycles later
        set_req(0, PLEN'(64'h8000_1040), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        chk("t1_ack", 64'(o_ack), 64'h1);
        chk("t1_tid", 64'(o_tid), 64'h0);
        chk("t1_size", 64'(o_size), 64'h7);
        cycle(1'b0, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        chk("t1_rtrn", 64'(o_rtrn), 64'h1);
        chk("t1_busy_hi", 64'(o_busy), 64'h1);
        cycle(1'b0, 1'b0, 0);
        chk("t1_busy_lo", 64'(o_busy), 64'h0);

        // same-line collision replays until the owner returns
        set_req(0, PLEN'(64'h8000_1000), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        set_req(1, PLEN'(64'h8000_1038), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        chk("t2_replay", 64'(o_replay), 64'h2);
        chk("t2_noreq", 64'(o_req), 64'h0);
        cycle(1'b1, 1'b1, 0);
        cycle(1'b1, 1'b0, 0);
        chk("t2_ack1", 64'(o_ack), 64'h2);
        cycle(1'b0, 1'b1, 1);

        // non-cacheable request on an in-flight line is not replayed
        set_req(0, PLEN'(64'h1000_0000), 1'b0, 3'b011);
        cycle(1'b1, 1'b0, 0);
        set_req(1, PLEN'(64'h1000_0000), 1'b1, 3'b010);
        cycle(1'b1, 1'b0, 0);
        chk("t3_noreplay", 64'(o_replay), 64'h0);
        chk("t3_ack1", 64'(o_ack), 64'h2);
        chk("t3_nc", 64'(o_nc), 64'h1);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 1);

        // round-robin order from pointer 0, then from pointer 1
        do_reset();
        for (int p = 0; p < N; p++) set_req(p, PLEN'(64'h8000_2000 + 64'(p) * 64'h40), 1'b0, 3'b111);
        for (int p = 0; p < N; p++) begin
            cycle(1'b1, 1'b0, 0);
            chk("t4_order0", 64'(o_ack), 64'(1) << p);
        end
        for (int p = 0; p < N; p++) cycle(1'b0, 1'b1, p);
        set_req(0, PLEN'(64'h8000_2400), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        for (int p = 0; p < N; p++) set_req(p, PLEN'(64'h8000_2000 + 64'(p) * 64'h40), 1'b0, 3'b111);
        for (int k = 1; k <= N; k++) begin
            cycle(1'b1, 1'b0, 0);
            chk("t4_order1", 64'(o_ack), 64'(1) << (k % N));
        end
        for (int p = 0; p < N; p++) cycle(1'b0, 1'b1, p);

        // stalled grant keeps the winner stable
        do_reset();
        set_req(0, PLEN'(64'h8000_3000), 1'b0, 3'b111);
        set_req(2, PLEN'(64'h8000_3100), 1'b0, 3'b111);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 1'b0, 0);
            chk("t5_paddr", 64'(o_paddr), 64'h8000_3000);
            chk("t5_noack", 64'(o_ack), 64'h0);
        end
        cycle(1'b1, 1'b0, 0);
        chk("t5_ack0", 64'(o_ack), 64'h1);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 2);
        // pointer at 2: a late request on port 2 must not steal from stalled port 0
        set_req(1, PLEN'(64'h8000_3200), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 1);
        set_req(0, PLEN'(64'h8000_3300), 1'b0, 3'b111);
        cycle(1'b0, 1'b0, 0);
        set_req(2, PLEN'(64'h8000_3400), 1'b0, 3'b111);
        cycle(1'b0, 1'b0, 0);
        chk("t5_lock_tid", 64'(o_tid), 64'h0);
        cycle(1'b1, 1'b0, 0);
        chk("t5_lock_ack", 64'(o_ack), 64'h1);
        cycle(1'b1, 1'b0, 0);
        cycle(1'b0, 1'b1, 0);
        cycle(1'b0, 1'b1, 2);

        // simultaneous return and grant, then reset with an entry in flight
        set_req(1, PLEN'(64'h8000_4000), 1'b0, 3'b111);
        cycle(1'b1, 1'b0, 0);
        set_req(2, PLEN'(64'h8000_4040), 1'b0, 3'b111);
        cycle(1'b1, 1'b1, 1);
        chk("t6_rtrn1", 64'(o_rtrn), 64'h2);
        chk("t6_ack2", 64'(o_ack), 64'h4);
        do_reset();
        cycle(1'b0, 1'b1, 2);
        chk("t6_late_rtrn", 64'(o_rtrn), 64'h0);
        chk("t6_busy", 64'(o_busy), 64'h0);

        // randomized traffic over a few neighbouring lines to provoke collisions
        for (int c = 0; c < 1500; c++) begin
            bit gnt, rv;
            int tid, npend;
            for (int p = 0; p < N; p++) begin
                if (!tb_req[p] && !m_pend[p] && $urandom_range(0, 3) == 0)
                    set_req(p, PLEN'(64'h8000_1000) + PLEN'($urandom_range(0, 2) * 64) + PLEN'($urandom_range(0, 63)),
                            $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)));
            end
            gnt   = $urandom_range(0, 3) != 0;
            rv    = 1'b0;
            tid   = 0;
            npend = 0;
            for (int p = 0; p < N; p++) npend += int'(m_pend[p]);
            if (npend > 0 && $urandom_range(0, 2) == 0) begin
                tid = int'($urandom_range(0, N - 1));
                while (!m_pend[tid]) tid = (tid + 1) % N;
                rv = 1'b1;
            end else if ($urandom_range(0, 15) == 0) begin
                tid = int'($urandom_range(0, 7));
                rv  = 1'b1;
            end
            cycle(gnt, rv, tid);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
